// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU (port 0) and a
// secondary master (port 1). Port 0 has fixed priority; a saturating
// starvation counter guarantees port 1 a grant after MAX_STARVE consecutive
// port-0 wins. Registered read data from memory is steered back to the
// port that issued the read one cycle earlier.
module mem_arbiter #(
  parameter int MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_funct3,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_funct3,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_wren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       force_p1;
  logic       sel_we;

  // Arbitration: port 1 is forced through once port 0 has used up its quota.
  always_comb begin
    force_p1 = p1_req && (starve_cnt == STARVE_LIMIT);
    p1_gnt   = force_p1 || (p1_req && !p0_req);
    p0_gnt   = p0_req && !force_p1;
  end

  // Memory-side mux; idle bus parks at zero with a word-sized funct3.
  always_comb begin
    sel_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_funct3 = 3'b010;
    if (p0_gnt) begin
      sel_we     = p0_we;
      mem_addr   = p0_addr;
      mem_wdata  = p0_wdata;
      mem_funct3 = p0_funct3;
    end else if (p1_gnt) begin
      sel_we     = p1_we;
      mem_addr   = p1_addr;
      mem_wdata  = p1_wdata;
      mem_funct3 = p1_funct3;
    end
    // Writes are suppressed while reset is held even though grants still follow req.
    mem_wren = sel_we && reset_n;
  end

  // Starvation counter: counts port-0 wins while port 1 waits, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (p0_gnt && p1_req) begin
      if (starve_cnt != STARVE_LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Read-return tracking: remembers whether a read was issued and by whom.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
      rd_owner <= p1_gnt;
    end
  end

  // Read data is gated to zero for the port that does not own the return.
  always_comb begin
    p0_rvalid = rd_pend && !rd_owner;
    p1_rvalid = rd_pend && rd_owner;
    p0_rdata  = p0_rvalid ? mem_rdata : 32'd0;
    p1_rdata  = p1_rvalid ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_arbiter;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_funct3, p1_funct3;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_wren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  int vectors = 0;
  int errors  = 0;

  mem_arbiter #(.MAX_STARVE(MS)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_funct3(p0_funct3), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_funct3(p1_funct3), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE0000 ^ (i * 32'h00010203);
  endfunction

  // Memory attached to the DUT's memory port, registered read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  // Reference model state: expected memory contents, how many port-0 wins
  // port 1 has sat through, and the read expected back next cycle.
  logic [31:0] ref_mem [256];
  int          p1_waited;
  bit          m_pend, m_owner;
  logic [31:0] m_rdata;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  function automatic void exp_grant(output bit g0, output bit g1);
    bit forced;
    forced = p1_req && (p1_waited >= MS);
    g1 = p1_req && (forced || !p0_req);
    g0 = p0_req && !forced;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit g0, g1, we;
    logic [31:0] a, d;
    if (!reset_n) begin
      p1_waited = 0;
      m_pend    = 0;
      m_owner   = 0;
    end else begin
      exp_grant(g0, g1);
      we = g0 ? p0_we : p1_we;
      a  = g0 ? p0_addr : p1_addr;
      d  = g0 ? p0_wdata : p1_wdata;
      m_pend  = (g0 || g1) && !we;
      m_owner = g1;
      if (g0 || g1) begin
        if (we) ref_mem[a[9:2]] = d;
        else m_rdata = ref_mem[a[9:2]];
      end
      if (g0 && p1_req) p1_waited = p1_waited + 1;
      else p1_waited = 0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit g0, g1, we;
    logic [31:0] a, d;
    logic [2:0] f;
    exp_grant(g0, g1);
    we = 0; a = 0; d = 0; f = 3'b010;
    if (g0) begin we = p0_we; a = p0_addr; d = p0_wdata; f = p0_funct3; end
    else if (g1) begin we = p1_we; a = p1_addr; d = p1_wdata; f = p1_funct3; end
    chk("m_p0_gnt", 32'(p0_gnt), 32'(g0));
    chk("m_p1_gnt", 32'(p1_gnt), 32'(g1));
    chk("m_wren", 32'(mem_wren), 32'(we && reset_n));
    chk("m_addr", mem_addr, a);
    chk("m_wdata", mem_wdata, d);
    chk("m_funct3", 32'(mem_funct3), 32'(f));
    chk("m_p0_rvalid", 32'(p0_rvalid), 32'(m_pend && !m_owner));
    chk("m_p1_rvalid", 32'(p1_rvalid), 32'(m_pend && m_owner));
    chk("m_p0_rdata", p0_rdata, (m_pend && !m_owner) ? m_rdata : 32'd0);
    chk("m_p1_rdata", p1_rdata, (m_pend && m_owner) ? m_rdata : 32'd0);
  end

  task automatic drv0(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; p0_funct3 = f;
  endtask

  task automatic drv1(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; p1_funct3 = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seq10;
    logic [4:0] seq5;
    int cnt;
    bit g0q, g1q;

    // Reset held with both ports requesting.
    reset_n = 1'b0;
    drv0(1, 1, 32'h40, 32'h11, 3'b010);
    drv1(1, 1, 32'h44, 32'h22, 3'b010);
    repeat (3) begin
      @(negedge clk);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    end

    // First read after reset.
    next_cycle();
    reset_n = 1'b1;
    drv1(0, 0, 32'h0, 32'h0, 3'b010);
    drv0(1, 0, 32'h100, 32'h0, 3'b010);
    @(negedge clk);
    chk("first_gnt", 32'(p0_gnt), 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    next_cycle();
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("first_rvalid", 32'(p0_rvalid), 32'd1);
    chk("first_rdata", p0_rdata, init_word(32'h40));
    chk("first_p1_rvalid", 32'(p1_rvalid), 32'd0);

    // Starvation bound with both ports reading continuously.
    next_cycle();
    drv0(1, 0, 32'h10, 32'h0, 3'b010);
    drv1(1, 0, 32'h20, 32'h0, 3'b010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq10[i] = p1_gnt;
      if (i == 5) begin
        chk("ilv_p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("ilv_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("ilv_p1_rdata", p1_rdata, init_word(8));
      end
      if (i == 6) chk("ilv_p0_back", 32'(p0_rvalid), 32'd1);
    end
    chk("starve_seq", 32'(seq10), 32'b10_0001_0000);

    // Port 1 idle: port 0 gets every cycle, then the quota starts fresh.
    next_cycle();
    drv1(0, 0, 32'h20, 32'h0, 3'b010);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p0_gnt) cnt++;
      if (i < 19) next_cycle();
    end
    chk("idle_p0_cnt", 32'(cnt), 32'd20);
    next_cycle();
    drv1(1, 0, 32'h20, 32'h0, 3'b010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seq5[i] = p1_gnt;
    end
    chk("fresh_quota_seq", 32'(seq5), 32'b10000);

    // Port-1 write followed by port-0 read of the same word.
    next_cycle();
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    drv1(1, 1, 32'h200, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    chk("wr_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("wr_wren", 32'(mem_wren), 32'd1);
    next_cycle();
    drv1(0, 0, 32'h0, 32'h0, 3'b010);
    drv0(1, 0, 32'h200, 32'h0, 3'b010);
    @(negedge clk);
    chk("rd_wren", 32'(mem_wren), 32'd0);
    chk("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("rd_no_p1_rvalid", 32'(p1_rvalid), 32'd0);
    next_cycle();
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rvalid2", 32'(p1_rvalid), 32'd0);

    // Reset asserted in the cycle after a read grant.
    next_cycle();
    drv0(1, 0, 32'h100, 32'h0, 3'b010);
    @(posedge clk);
    #2;
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    reset_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(p0_rvalid), 32'd0);
    @(negedge clk);
    chk("midrst_rvalid_hold", 32'(p0_rvalid), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_rvalid", 32'(p0_rvalid), 32'd0);
      next_cycle();
    end
    drv0(1, 0, 32'h100, 32'h0, 3'b010);
    next_cycle();
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("regrant_rvalid", 32'(p0_rvalid), 32'd1);

    // Randomized traffic obeying the requester hold contract.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      g0q = p0_gnt;
      g1q = p1_gnt;
      #1;
      if (!(p0_req && !g0q))
        drv0($urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0,
             {22'd0, 8'($urandom), 2'b00}, $urandom, 3'($urandom));
      if (!(p1_req && !g1q))
        drv1($urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
             {22'd0, 8'($urandom), 2'b00}, $urandom, 3'($urandom));
    end
    next_cycle();
    drv0(0, 0, 32'h0, 32'h0, 3'b010);
    drv1(0, 0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
